// File: rtl/dsp_demod_pkg.sv
// Shared widths and FSM state type for the FSK discriminator demodulator.
// Accumulator default = discriminator width + 16 guard bits, for up to 65535 outputs per symbol.
package dsp_demod_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DISC_W_DEF = 2*DATA_W_DEF + 1;
  localparam int ACC_W_DEF  = DISC_W_DEF + 16;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

endpackage

// File: rtl/cplx_disc.sv
// Differential phase discriminator d = im*re_prev - re*im_prev; 3-cycle pipeline, no backpressure.
// flush drops in-flight values and forgets the previous sample, so the next sample only primes it.
module cplx_disc
  import dsp_demod_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       in_vld,
  input  logic signed [DATA_W-1:0]   in_re,
  input  logic signed [DATA_W-1:0]   in_im,
  input  logic                       flush,
  output logic                       d_vld,
  output logic signed [2*DATA_W:0]   d
);

  logic                        has_prev;
  logic signed [DATA_W-1:0]    last_re, last_im;
  logic signed [DATA_W-1:0]    cur_re, cur_im, prv_re, prv_im;
  logic                        s1_vld, s2_vld;
  logic signed [2*DATA_W-1:0]  p_a, p_b;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      has_prev <= 1'b0;
      last_re  <= '0;
      last_im  <= '0;
      cur_re   <= '0;
      cur_im   <= '0;
      prv_re   <= '0;
      prv_im   <= '0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      p_a      <= '0;
      p_b      <= '0;
      d_vld    <= 1'b0;
      d        <= '0;
    end else if (flush) begin
      has_prev <= 1'b0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      d_vld    <= 1'b0;
    end else begin
      // gap cycles leave last_* untouched, so the next d spans the gap
      s1_vld <= in_vld && has_prev;
      if (in_vld) begin
        cur_re   <= in_re;
        cur_im   <= in_im;
        prv_re   <= last_re;
        prv_im   <= last_im;
        last_re  <= in_re;
        last_im  <= in_im;
        has_prev <= 1'b1;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        p_a <= cur_im * prv_re;
        p_b <= cur_re * prv_im;
      end
      d_vld <= s2_vld;
      if (s2_vld)
        d <= {p_a[2*DATA_W-1], p_a} - {p_b[2*DATA_W-1], p_b};
    end
  end

endmodule

// File: rtl/fsk_disc_demod.sv
// FSK demodulator: integrates the discriminator over a symbol, one bit 4 edges after its last sample.
// Output is a one-deep AXI-S register; a decision arriving while stalled is dropped and flagged.
module fsk_disc_demod
  import dsp_demod_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int IDLE_GAP    = 8,
  parameter bit HIGH_IS_ONE = 1'b0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_data_tvalid,
  input  logic [2*DATA_W-1:0]      s_axis_data_tdata,
  input  logic [15:0]              cfg_symbol_len,
  input  logic signed [ACC_W-1:0]  cfg_threshold,
  output logic                     m_axis_bit_tvalid,
  input  logic                     m_axis_bit_tready,
  output logic [7:0]               m_axis_bit_tdata,
  output logic                     bit_overflow,
  output logic                     burst_end
);

  localparam int DISC_W = 2*DATA_W + 1;
  localparam int GAP_W  = $clog2(IDLE_GAP + 1);

  state_t                    state;
  logic [GAP_W-1:0]          gap_cnt;
  logic [15:0]               len_q, sym_cnt;
  logic signed [ACC_W-1:0]   thr_q, acc, acc_done, acc_sum;
  logic                      dec_vld, out_bit;
  logic                      d_vld, gap_end, acc_en, sym_done, dec_bit;
  logic signed [DISC_W-1:0]  d;
  logic signed [DATA_W-1:0]  s_re, s_im;

  assign s_re = s_axis_data_tdata[DATA_W-1:0];
  assign s_im = s_axis_data_tdata[2*DATA_W-1:DATA_W];

  cplx_disc #(.DATA_W(DATA_W)) u_disc (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_vld  (s_axis_data_tvalid),
    .in_re   (s_re),
    .in_im   (s_im),
    .flush   (gap_end),
    .d_vld   (d_vld),
    .d       (d)
  );

  assign gap_end  = (state == ST_RUN) && !s_axis_data_tvalid && (gap_cnt == GAP_W'(IDLE_GAP - 1));
  assign acc_en   = d_vld && (state == ST_RUN) && !gap_end;
  assign sym_done = (sym_cnt == len_q - 16'd1);
  assign acc_sum  = acc + {{(ACC_W-DISC_W){d[DISC_W-1]}}, d};
  assign dec_bit  = HIGH_IS_ONE ? (acc_done > thr_q) : (acc_done <= thr_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      len_q     <= '0;
      thr_q     <= '0;
      sym_cnt   <= '0;
      acc       <= '0;
      acc_done  <= '0;
      dec_vld   <= 1'b0;
      burst_end <= 1'b0;
    end else begin
      burst_end <= 1'b0;
      dec_vld   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_axis_data_tvalid) begin
            state   <= ST_RUN;
            len_q   <= cfg_symbol_len;
            thr_q   <= cfg_threshold;
            gap_cnt <= '0;
            acc     <= '0;
            sym_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (s_axis_data_tvalid) begin
            gap_cnt <= '0;
          end else if (gap_end) begin
            state     <= ST_IDLE;
            burst_end <= 1'b1;
            gap_cnt   <= '0;
            acc       <= '0;
            sym_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          if (acc_en) begin
            if (sym_done) begin
              acc_done <= acc_sum;
              dec_vld  <= 1'b1;
              acc      <= '0;
              sym_cnt  <= '0;
            end else begin
              acc     <= acc_sum;
              sym_cnt <= sym_cnt + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // a decision meeting a handshake in the same cycle replaces the accepted bit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_bit_tvalid <= 1'b0;
      out_bit           <= 1'b0;
      bit_overflow      <= 1'b0;
    end else if (dec_vld) begin
      if (!m_axis_bit_tvalid || m_axis_bit_tready) begin
        m_axis_bit_tvalid <= 1'b1;
        out_bit           <= dec_bit;
      end else begin
        bit_overflow <= 1'b1;
      end
    end else if (m_axis_bit_tvalid && m_axis_bit_tready) begin
      m_axis_bit_tvalid <= 1'b0;
    end
  end

  assign m_axis_bit_tdata = {7'd0, out_bit};

endmodule

// File: tb/tb_fsk_disc_demod.sv
// Directed bench for fsk_disc_demod: DDS-style tones at 4 MHz (inc 2621) and 10 MHz (inc 6553), amplitude 32000.
// Expected bits are hand-derived: 98 d per symbol gives ~2.5e10 (4 MHz) or ~5.9e10 (10 MHz) against 42e9.
module tb_fsk_disc_demod;

  localparam int ACC_W = 49;

  logic              aclk, aresetn;
  logic              s_vld;
  logic [31:0]       s_dat;
  logic [15:0]       cfg_len;
  logic signed [ACC_W-1:0] cfg_thr;
  logic              m_vld, m_rdy, ovf, bend;
  logic [7:0]        m_dat;

  fsk_disc_demod dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_vld),
    .s_axis_data_tdata  (s_dat),
    .cfg_symbol_len     (cfg_len),
    .cfg_threshold      (cfg_thr),
    .m_axis_bit_tvalid  (m_vld),
    .m_axis_bit_tready  (m_rdy),
    .m_axis_bit_tdata   (m_dat),
    .bit_overflow       (ovf),
    .burst_end          (bend)
  );

  typedef struct {
    int inc;
    int nsamp;
    bit exp_bit;
    bit new_burst;
  } vec_t;

  vec_t        vecs[16];
  int          nvec, nmis, cyc, be_cnt, be0, j, mdl_len, hs_rd;
  logic [15:0] ph;
  bit          hs_bit[$];
  int          hs_cyc[$];
  bit          exp_bits[$];
  int          exp_edge[$];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial be_cnt = 0;
  always @(negedge aclk) begin
    if (aresetn && m_vld && m_rdy) begin
      hs_bit.push_back(m_dat[0]);
      hs_cyc.push_back(cyc);
    end
    if (bend) be_cnt = be_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(0.5 - x);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // one valid sample; the model records the sampling edge of every symbol-completing sample
  task automatic sample(input int inc);
    real a;
    int  re, im;
    @(posedge aclk);
    #1;
    ph = ph + 16'(inc);
    a  = 6.283185307179586 * real'(ph) / 65536.0;
    re = rnd(32000.0 * $cos(a));
    im = rnd(32000.0 * $sin(a));
    s_dat = {im[15:0], re[15:0]};
    s_vld = 1'b1;
    j = j + 1;
    if (j == 1) mdl_len = int'(cfg_len);
    else if ((j - 1) % mdl_len == 0) exp_edge.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
      s_vld = 1'b0;
    end
  endtask

  task automatic start_burst();
    j = 0;
  endtask

  task automatic check_stream(input string nm, input bit chk_lat);
    int n;
    n = exp_bits.size();
    chk({nm, "_nbits"}, longint'(hs_bit.size() - hs_rd), longint'(n));
    for (int i = 0; i < n; i++) begin
      if (hs_rd + i < hs_bit.size()) begin
        chk($sformatf("%s_bit%0d", nm, i), longint'(hs_bit[hs_rd+i]), longint'(exp_bits[i]));
        if (chk_lat && i < exp_edge.size())
          chk($sformatf("%s_lat%0d", nm, i), longint'(hs_cyc[hs_rd+i] - exp_edge[i]), 64'd4);
      end
    end
    hs_rd = hs_bit.size();
    exp_bits.delete();
    exp_edge.delete();
  endtask

  initial begin
    logic [12:0] pat;
    nvec = 0; nmis = 0; hs_rd = 0; j = 0; mdl_len = 1; ph = '0;
    pat = 13'b0101010101010;
    for (int i = 0; i < 16; i++) begin
      if (i < 13) begin
        vecs[i].inc       = pat[i] ? 2621 : 6553;
        vecs[i].nsamp     = 99;
        vecs[i].exp_bit   = pat[i];
        vecs[i].new_burst = (i == 0);
      end else begin
        vecs[i].inc       = 6553;
        vecs[i].nsamp     = (i == 13) ? 99 : 98;
        vecs[i].exp_bit   = 1'b0;
        vecs[i].new_burst = (i == 13);
      end
    end

    aresetn = 1'b0; s_vld = 1'b0; s_dat = '0; m_rdy = 1'b1;
    cfg_len = 16'd98; cfg_thr = 49'sd42000000000;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", longint'(m_vld), 0);
    chk("rst_tdata", longint'(m_dat), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_bend", longint'(bend), 0);
    aresetn = 1'b1;

    // FSK pattern burst (99 samples/bit) followed by a constant 10 MHz burst (3 symbols)
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].new_burst) begin
        idle(12);
        start_burst();
      end
      repeat (vecs[i].nsamp) sample(vecs[i].inc);
      exp_bits.push_back(vecs[i].exp_bit);
    end
    idle(12);
    check_stream("tone", 1'b1);
    chk("tone_ovf", longint'(ovf), 0);

    // short gap mid-symbol must not disturb the decisions
    be0 = be_cnt;
    start_burst();
    repeat (50) sample(2621);
    idle(5);
    repeat (49) sample(2621);
    repeat (98) sample(6553);
    idle(12);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
    check_stream("gap5", 1'b1);
    chk("gap5_bend", longint'(be_cnt - be0), 1);

    // IDLE_GAP-long gap ends the burst and drops the partial symbol
    be0 = be_cnt;
    start_burst();
    repeat (50) sample(2621);
    idle(8);
    start_burst();
    repeat (99) sample(6553);
    chk("gap8_bend", longint'(be_cnt - be0), 1);
    idle(12);
    exp_bits.push_back(1'b0);
    check_stream("gap8", 1'b1);

    // cfg changes mid-burst are ignored, then applied on the next burst
    start_burst();
    repeat (2) sample(6553);
    cfg_len = 16'd50;
    cfg_thr = 49'sd100000000000;
    repeat (195) sample(6553);
    idle(12);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
    check_stream("cfghold", 1'b1);
    cfg_thr = 49'sd42000000000;
    start_burst();
    repeat (101) sample(6553);
    idle(12);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    check_stream("cfgnew", 1'b1);
    chk("cfg_ovf", longint'(ovf), 0);

    // stalled sink: first bit held, later decisions dropped and flagged
    cfg_len = 16'd98;
    m_rdy = 1'b0;
    start_burst();
    repeat (99) sample(2621);
    repeat (6) sample(6553);
    chk("stall1_vld", longint'(m_vld), 1);
    chk("stall1_bit", longint'(m_dat), 1);
    chk("stall1_ovf", longint'(ovf), 0);
    repeat (92) sample(6553);
    idle(6);
    chk("stall2_vld", longint'(m_vld), 1);
    chk("stall2_bit", longint'(m_dat), 1);
    chk("stall2_ovf", longint'(ovf), 1);
    start_burst();
    repeat (98) sample(6553);
    idle(12);
    chk("stall3_bit", longint'(m_dat), 1);
    exp_bits.push_back(1'b1);
    m_rdy = 1'b1;
    idle(4);
    check_stream("stall", 1'b0);
    chk("stall_drained", longint'(m_vld), 0);

    // reset mid-burst with a pending bit and sticky overflow
    m_rdy = 1'b0;
    start_burst();
    repeat (200) sample(2621);
    aresetn = 1'b0;
    repeat (2) sample(2621);
    chk("mrst_tvalid", longint'(m_vld), 0);
    chk("mrst_tdata", longint'(m_dat), 0);
    chk("mrst_ovf", longint'(ovf), 0);
    chk("mrst_bend", longint'(bend), 0);
    s_vld = 1'b0;
    m_rdy = 1'b1;
    aresetn = 1'b1;
    start_burst();
    repeat (96) sample(2621);
    idle(12);
    check_stream("postrst", 1'b0);
    chk("postrst_ovf", longint'(ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
